// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU controller slice:
//   - alu_op_e  : 4-bit opcode {mode, opsel[2:0]} of the legal operations
//   - state_e   : controller FSM states
//   - FLAG_*    : bit positions inside the 4-bit flag vector {c,z,o,s}
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUBWB  = 4'h1,
    OP_MOV    = 4'h2,
    OP_SUB    = 4'h3,
    OP_INC    = 4'h4,
    OP_DEC    = 4'h5,
    OP_ADDINC = 4'h6,
    OP_AND    = 4'h8,
    OP_OR     = 4'h9,
    OP_XOR    = 4'hA,
    OP_NOT    = 4'hB,
    OP_SHL    = 4'hD
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Flag vector layout is {c, z, o, s}, MSB first.
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_S = 0;

endpackage

// File: rtl/alu_128bit.sv
// ---------------------------------------------------------------------------
// alu_128bit
//   Combinational ALU attached to alu_ctrl's alu_* ports.
//   op1, op2      : operands
//   mode, opsel   : operation select (mode 0 arithmetic, mode 1 logic/shift)
//   result        : operation result
//   c/z/o/s_flag  : carry, zero, signed overflow, sign
//   Arithmetic ops are all formed as op1 + y + cin so one adder serves
//   add/sub/inc/dec; subtraction carry therefore means "no borrow".
// ---------------------------------------------------------------------------
module alu_128bit #(
  parameter int DWIDTH = 128
) (
  input  logic [DWIDTH-1:0] op1,
  input  logic [DWIDTH-1:0] op2,
  input  logic [2:0]        opsel,
  input  logic              mode,
  output logic [DWIDTH-1:0] result,
  output logic              c_flag,
  output logic              z_flag,
  output logic              o_flag,
  output logic              s_flag
);

  logic [DWIDTH-1:0] y_s;
  logic              cin_s;
  logic [DWIDTH:0]   sum_s;

  // Operation select, shared adder and flag generation
  always_comb begin
    y_s    = '0;
    cin_s  = 1'b0;
    result = '0;
    c_flag = 1'b0;
    o_flag = 1'b0;
    if (!mode) begin
      case (opsel)
        3'd0:    y_s = op2;                      // add
        3'd1:    y_s = ~op2;                     // sub with borrow in
        3'd2:    y_s = '0;                       // mov
        3'd3:    begin y_s = ~op2; cin_s = 1'b1; end  // sub
        3'd4:    cin_s = 1'b1;                   // inc
        3'd5:    y_s = '1;                       // dec
        3'd6:    begin y_s = op2; cin_s = 1'b1; end   // add + 1
        default: y_s = '0;
      endcase
    end else begin
      y_s = '0;
    end
    sum_s = {1'b0, op1} + {1'b0, y_s} + {{DWIDTH{1'b0}}, cin_s};
    if (!mode) begin
      result = sum_s[DWIDTH-1:0];
      c_flag = sum_s[DWIDTH];
      o_flag = (op1[DWIDTH-1] == y_s[DWIDTH-1]) && (result[DWIDTH-1] != op1[DWIDTH-1]);
    end else begin
      case (opsel)
        3'd0:    result = op1 & op2;
        3'd1:    result = op1 | op2;
        3'd2:    result = op1 ^ op2;
        3'd3:    result = ~op1;
        3'd5:    begin result = {op1[DWIDTH-2:0], 1'b0}; c_flag = op1[DWIDTH-1]; end
        default: result = '0;
      endcase
    end
    z_flag = (result == '0);
    s_flag = result[DWIDTH-1];
  end

endmodule

// File: rtl/alu_opdec.sv
// ---------------------------------------------------------------------------
// alu_opdec
//   Combinational opcode decoder.
//   op_i     : 4-bit request opcode
//   mode_o   : ALU mode (0 arithmetic, 1 logic/shift)
//   opsel_o  : ALU operation select within the mode
//   legal_o  : 1 when op_i is one of the supported operations
//   Illegal opcodes decode to mode 0 / opsel 0 so the ALU sees a benign
//   selection; the controller masks the result anyway.
// ---------------------------------------------------------------------------
module alu_opdec
  import alu_pkg::*;
(
  input  logic [3:0] op_i,
  output logic       mode_o,
  output logic [2:0] opsel_o,
  output logic       legal_o
);

  // Legal-opcode lookup and field split
  always_comb begin
    legal_o = 1'b0;
    case (op_i)
      OP_ADD, OP_SUBWB, OP_MOV, OP_SUB, OP_INC, OP_DEC, OP_ADDINC,
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL: legal_o = 1'b1;
      default:                               legal_o = 1'b0;
    endcase
    if (legal_o) begin
      mode_o  = op_i[3];
      opsel_o = op_i[2:0];
    end else begin
      mode_o  = 1'b0;
      opsel_o = 3'd0;
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// ---------------------------------------------------------------------------
// alu_ctrl
//   Request/response controller around an external combinational ALU.
//   Three-state FSM: IDLE (accept) -> EXEC (ALU evaluates) -> RESP (hold
//   response until consumed). One operation per 3 cycles at best.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     req_valid/req_ready         request handshake
//     req_op, req_op1, req_op2    opcode {mode,opsel} and operands
//     alu_op1/op2/opsel/mode      registered drive to the ALU
//     alu_result, alu_*_flag      ALU outputs
//     rsp_valid/rsp_ready         response handshake
//     rsp_result/flags/err        response payload, flags {c,z,o,s}
//     stat_flags, op_count        flags of last legal op, saturating count
// ---------------------------------------------------------------------------
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DWIDTH-1:0] req_op1,
  input  logic [DWIDTH-1:0] req_op2,
  output logic [DWIDTH-1:0] alu_op1,
  output logic [DWIDTH-1:0] alu_op2,
  output logic [2:0]        alu_opsel,
  output logic              alu_mode,
  input  logic [DWIDTH-1:0] alu_result,
  input  logic              alu_c_flag,
  input  logic              alu_z_flag,
  input  logic              alu_o_flag,
  input  logic              alu_s_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic [3:0]        stat_flags,
  output logic [CNTW-1:0]   op_count
);

  state_e            state_q, state_d;
  logic              capture_s;
  logic              complete_s;
  logic              dec_mode_s;
  logic [2:0]        dec_opsel_s;
  logic              dec_legal_s;
  logic [3:0]        alu_flags_s;

  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              legal_q;
  logic [DWIDTH-1:0] alu_op1_q;
  logic [DWIDTH-1:0] alu_op2_q;
  logic [2:0]        alu_opsel_q;
  logic              alu_mode_q;
  logic [DWIDTH-1:0] rsp_result_q;
  logic [3:0]        rsp_flags_q;
  logic              rsp_err_q;
  logic [3:0]        stat_flags_q;
  logic [CNTW-1:0]   op_count_q;

  alu_opdec u_opdec (
    .op_i    (req_op),
    .mode_o  (dec_mode_s),
    .opsel_o (dec_opsel_s),
    .legal_o (dec_legal_s)
  );

  // Pack ALU flags into the {c,z,o,s} layout
  always_comb begin
    alu_flags_s         = 4'd0;
    alu_flags_s[FLAG_C] = alu_c_flag;
    alu_flags_s[FLAG_Z] = alu_z_flag;
    alu_flags_s[FLAG_O] = alu_o_flag;
    alu_flags_s[FLAG_S] = alu_s_flag;
  end

  // FSM next-state and handshake strobes
  always_comb begin
    state_d    = state_q;
    capture_s  = 1'b0;
    complete_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          capture_s = 1'b1;
          state_d   = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          complete_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request capture, response capture and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      legal_q      <= 1'b0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_opsel_q  <= 3'd0;
      alu_mode_q   <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'd0;
      rsp_err_q    <= 1'b0;
      stat_flags_q <= 4'd0;
      op_count_q   <= '0;
    end else begin
      state_q     <= state_d;
      // Handshake outputs are registered copies of the next state.
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      if (capture_s) begin
        alu_op1_q   <= req_op1;
        alu_op2_q   <= req_op2;
        alu_opsel_q <= dec_opsel_s;
        alu_mode_q  <= dec_mode_s;
        legal_q     <= dec_legal_s;
      end
      if (state_q == ST_EXEC) begin
        // Illegal opcodes produce an all-zero payload with only err set.
        rsp_result_q <= legal_q ? alu_result : '0;
        rsp_flags_q  <= legal_q ? alu_flags_s : 4'd0;
        rsp_err_q    <= ~legal_q;
      end
      if (complete_s && !rsp_err_q) begin
        stat_flags_q <= rsp_flags_q;
        if (op_count_q != {CNTW{1'b1}}) begin
          op_count_q <= op_count_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign alu_opsel  = alu_opsel_q;
  assign alu_mode   = alu_mode_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign stat_flags = stat_flags_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl
//   Directed bench for alu_ctrl (DWIDTH=32, CNTW=4) wired to alu_128bit.
// ---------------------------------------------------------------------------
module tb_alu_ctrl;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_op = 4'd0;
  logic [DW-1:0] req_op1 = '0;
  logic [DW-1:0] req_op2 = '0;
  logic [DW-1:0] alu_op1, alu_op2, alu_result;
  logic [2:0]    alu_opsel;
  logic          alu_mode;
  logic          alu_c_flag, alu_z_flag, alu_o_flag, alu_s_flag;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_result;
  logic [3:0]    rsp_flags;
  logic          rsp_err;
  logic [3:0]    stat_flags;
  logic [CW-1:0] op_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_ctrl #(.DWIDTH(DW), .CNTW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_op1(req_op1), .req_op2(req_op2),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opsel(alu_opsel), .alu_mode(alu_mode),
    .alu_result(alu_result),
    .alu_c_flag(alu_c_flag), .alu_z_flag(alu_z_flag),
    .alu_o_flag(alu_o_flag), .alu_s_flag(alu_s_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .stat_flags(stat_flags), .op_count(op_count)
  );

  alu_128bit #(.DWIDTH(DW)) u_alu (
    .op1(alu_op1), .op2(alu_op2), .opsel(alu_opsel), .mode(alu_mode),
    .result(alu_result),
    .c_flag(alu_c_flag), .z_flag(alu_z_flag), .o_flag(alu_o_flag), .s_flag(alu_s_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request in IDLE; returns with the DUT in RESP.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_op = op; req_op1 = a; req_op2 = b; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
    checks++; if ({rsp_flags, rsp_err} !== 5'b0) begin errors++; $display("FAIL reset_rsp_flags_err got=%b exp=0", {rsp_flags, rsp_err}); end
    checks++; if ({alu_op1, alu_op2, alu_opsel, alu_mode} !== 68'h0) begin errors++; $display("FAIL reset_alu_drive got=%h exp=0", {alu_op1, alu_op2, alu_opsel, alu_mode}); end
    checks++; if ({stat_flags, op_count} !== 8'h00) begin errors++; $display("FAIL reset_stats got=%h exp=00", {stat_flags, op_count}); end
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_add_latency();
    rsp_ready = 1'b1;
    req_op = 4'h0; req_op1 = 32'd5; req_op2 = 32'd3; req_valid = 1'b1;
    tick();                                 // cycle N+1: EXEC
    req_valid = 1'b0;
    checks++; if ({req_ready, rsp_valid} !== 2'b00) begin errors++; $display("FAIL add_exec_hs got=%b exp=00", {req_ready, rsp_valid}); end
    checks++; if ({alu_op1, alu_op2} !== {32'd5, 32'd3}) begin errors++; $display("FAIL add_alu_ops got=%h exp=%h", {alu_op1, alu_op2}, {32'd5, 32'd3}); end
    tick();                                 // cycle N+2: RESP
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_latency got=%b exp=1", rsp_valid); end
    checks++; if (rsp_result !== 32'd8) begin errors++; $display("FAIL add_result got=%h exp=8", rsp_result); end
    checks++; if ({rsp_flags, rsp_err} !== 5'b0000_0) begin errors++; $display("FAIL add_flags_err got=%b exp=00000", {rsp_flags, rsp_err}); end
    tick();                                 // handshake taken, back in IDLE
    rsp_ready = 1'b0;
    checks++; if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL add_idle_hs got=%b exp=10", {req_ready, rsp_valid}); end
    checks++; if (op_count !== 4'd1) begin errors++; $display("FAIL add_op_count got=%0d exp=1", op_count); end
  endtask

  task automatic test_sub_zero();
    issue(4'h3, 32'h1234, 32'h1234);
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL sub_result got=%h exp=0", rsp_result); end
    // a + ~b + 1 carries out (no borrow) and is zero: {c,z,o,s} = 1100
    checks++; if (rsp_flags !== 4'b1100) begin errors++; $display("FAIL sub_flags got=%b exp=1100", rsp_flags); end
    handshake();
    checks++; if (stat_flags !== 4'b1100) begin errors++; $display("FAIL sub_stat_flags got=%b exp=1100", stat_flags); end
    checks++; if (op_count !== 4'd2) begin errors++; $display("FAIL sub_op_count got=%0d exp=2", op_count); end
  endtask

  task automatic test_illegal();
    issue(4'h7, 32'hFFFF_FFFF, 32'h1);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ill_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL ill_result got=%h exp=0", rsp_result); end
    checks++; if ({rsp_flags, rsp_err} !== 5'b0000_1) begin errors++; $display("FAIL ill_flags_err got=%b exp=00001", {rsp_flags, rsp_err}); end
    handshake();
    checks++; if (stat_flags !== 4'b1100) begin errors++; $display("FAIL ill_stat_flags got=%b exp=1100", stat_flags); end
    checks++; if (op_count !== 4'd2) begin errors++; $display("FAIL ill_op_count got=%0d exp=2", op_count); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ill_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_stall();
    issue(4'hD, 32'h8000_0001, 32'h0);
    // A competing request during RESP must be ignored.
    req_op = 4'h0; req_op1 = 32'hDEAD; req_op2 = 32'hBEEF; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if ({rsp_valid, req_ready} !== 2'b10) begin errors++; $display("FAIL stall_hs[%0d] got=%b exp=10", k, {rsp_valid, req_ready}); end
      checks++; if ({rsp_result, rsp_flags, rsp_err} !== {32'h2, 4'b1000, 1'b0}) begin errors++; $display("FAIL stall_payload[%0d] got=%h exp=%h", k, {rsp_result, rsp_flags, rsp_err}, {32'h2, 4'b1000, 1'b0}); end
      checks++; if (alu_op1 !== 32'h8000_0001) begin errors++; $display("FAIL stall_alu_op1[%0d] got=%h exp=80000001", k, alu_op1); end
      tick();
    end
    req_valid = 1'b0;
    handshake();
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL stall_done_hs got=%b exp=01", {rsp_valid, req_ready}); end
    checks++; if ({stat_flags, op_count} !== {4'b1000, 4'd3}) begin errors++; $display("FAIL stall_stats got=%h exp=83", {stat_flags, op_count}); end
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_no_queue got=%b exp=1", req_ready); end
  endtask

  task automatic test_reset_mid_exec();
    req_op = 4'h0; req_op1 = 32'd7; req_op2 = 32'd9; req_valid = 1'b1;
    tick();                                 // now in EXEC
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL rstx_hs got=%b exp=10", {req_ready, rsp_valid}); end
    checks++; if ({stat_flags, op_count} !== 8'h00) begin errors++; $display("FAIL rstx_stats got=%h exp=00", {stat_flags, op_count}); end
    checks++; if (alu_op1 !== 32'h0) begin errors++; $display("FAIL rstx_alu_op1 got=%h exp=0", alu_op1); end
    tick();
    checks++; if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL rstx_discard got=%b exp=10", {req_ready, rsp_valid}); end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 15; i++) begin
      issue(4'h4, DW'(i), 32'h0);
      checks++; if ({rsp_result, rsp_flags} !== {DW'(i + 1), 4'b0000}) begin errors++; $display("FAIL sat_inc[%0d] got=%h exp=%h", i, {rsp_result, rsp_flags}, {DW'(i + 1), 4'b0000}); end
      handshake();
      checks++; if (op_count !== CW'(i)) begin errors++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, op_count, i); end
    end
    issue(4'hB, 32'h0, 32'h0);
    checks++; if ({rsp_result, rsp_flags} !== {32'hFFFF_FFFF, 4'b0001}) begin errors++; $display("FAIL sat_not got=%h exp=%h", {rsp_result, rsp_flags}, {32'hFFFF_FFFF, 4'b0001}); end
    handshake();
    checks++; if (op_count !== 4'hF) begin errors++; $display("FAIL sat_hold got=%h exp=F", op_count); end
    checks++; if (stat_flags !== 4'b0001) begin errors++; $display("FAIL sat_stat_flags got=%b exp=0001", stat_flags); end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_sub_zero();
    test_illegal();
    test_stall();
    test_reset_mid_exec();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter DWIDTH, default 32, operand/result width.
REQ-002 Parameter CNTW, default 16, width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_op  input  4  opcode {mode, opsel[2:0]}.
REQ-008 req_op1, req_op2  input  DWIDTH  operands.
REQ-009 alu_op1, alu_op2  output  DWIDTH  operands driven to the combinational ALU.
REQ-010 alu_opsel  output  3  and  alu_mode  output  1  ALU operation select.
REQ-011 alu_result  input  DWIDTH  and  alu_c/z/o/s_flag  input  1 each  ALU outputs.
REQ-012 rsp_valid  output  1  response present; rsp_ready  input  1  consumer accepts.
REQ-013 rsp_result  output  DWIDTH  and  rsp_flags  output  4  ordered {c,z,o,s}.
REQ-014 rsp_err  output  1  illegal opcode indication.
REQ-015 stat_flags  output  4  flags of last legal operation; op_count  output  CNTW  legal responses delivered.

Function
REQ-016 FSM states IDLE, EXEC, RESP; exactly one state active.
REQ-017 IDLE: req_ready=1; req_valid=1 captures req_op, req_op1, req_op2 into registers, next state EXEC.
REQ-018 EXEC: req_ready=0; ALU driven from captured registers; at cycle end alu_result and flags captured into response registers; next state RESP.
REQ-019 RESP: rsp_valid=1, req_ready=0; rsp_ready=1 completes the handshake, next state IDLE; otherwise remain.
REQ-020 Latency: request accepted in cycle N gives rsp_valid in cycle N+2; peak throughput one operation per 3 cycles.
REQ-021 rsp_result, rsp_flags, rsp_err remain stable while rsp_valid=1 and rsp_ready=0.
REQ-022 alu_op1/alu_op2/alu_opsel/alu_mode are registered outputs, changing only on request capture.
REQ-023 Legal opcodes: 0 add, 1 subwb, 2 mov, 3 sub, 4 inc, 5 dec, 6 addinc, 8 and, 9 or, A xor, B not, D shl.
REQ-024 Illegal opcodes (7, C, E, F): full FSM sequence still runs; response is rsp_result=0, rsp_flags=0, rsp_err=1.
REQ-025 Illegal opcodes leave stat_flags and op_count unchanged.
REQ-026 On a legal response handshake, stat_flags is loaded with rsp_flags and op_count increments by 1.
REQ-027 op_count saturates at all-ones; no wrap-around.
REQ-028 req_valid outside IDLE is ignored; no request is queued.

Reset
REQ-029 rst=1 at a clock edge forces IDLE regardless of current state, including mid-EXEC or mid-RESP; any pending response is discarded.
REQ-030 Reset values: all ALU drive outputs 0, rsp_valid 0, rsp_result 0, rsp_flags 0, rsp_err 0, stat_flags 0, op_count 0; req_ready 1 on the first cycle after reset release.

Structure
REQ-031 Shared package alu_pkg holds the opcode enum (4-bit, values per REQ-023), the FSM state enum, and the flag bit-index constants.
REQ-032 Sub-module alu_opdec (combinational) maps the opcode to {mode, opsel, legal}; alu_ctrl instantiates it once.
REQ-033 The ALU is external to alu_ctrl; the bench and top level connect alu_128bit to the alu_* ports.

Verification
REQ-034 Bench covers: op 0 with 5 and 3, rsp_ready=1 -> rsp_valid at N+2, result 8, flags z=0, err=0, op_count=1.
REQ-035 Bench covers: op 3 with 0x1234 and 0x1234 -> result 0, z=1, stat_flags z bit=1 after the handshake.
REQ-036 Bench covers: op 7 with any operands -> result 0, flags 0, err=1; stat_flags and op_count unchanged.
REQ-037 Bench covers: rsp_ready held 0 for 5 cycles in RESP -> response outputs stable and req_ready=0 throughout; completion follows rsp_ready=1.
REQ-038 Bench covers: rst pulsed during EXEC -> next cycle state IDLE, rsp_valid=0, op_count=0, req_ready=1.
REQ-039 Bench covers: op_count preloaded via 2^CNTW-1 legal operations (CNTW=4 build) plus one more -> op_count stays 4'hF.
